spw_light_pll_supervisor: RTL and testbench



---
 rtl/spw_light_pll_supervisor.sv | 157 +++++++++++++++
 tb/tb_spw_light_pll_supervisor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spw_light_pll_supervisor.sv
// Purpose : PLL bring-up supervisor: pulses pll_rst, qualifies the async lock flag, releases sys_rst_n.
// Latency : locked edge -> internal effect after 2-flop sync (+1 edge to register outputs); release after STABLE_CYCLES.
// Backpressure: none; restart is a one-cycle request that always wins over other transitions.
//
// Ports:
//   refclk     reference clock (same source as PLL refclk)
//   rst_n      asynchronous active-low reset (already synchronized on deassertion)
//   locked     PLL lock flag, asynchronous to refclk
//   restart    single-cycle request to re-run PLL bring-up
//   pll_rst    active-high reset to the PLL
//   sys_rst_n  active-low reset to the downstream core
//   ready      PLL qualified and system running
//   fault      lock retries exhausted; PLL held in reset
//   retry_cnt  timeout retries used in the current bring-up
//   loss_cnt   saturating count of lock losses while running (cleared only by rst_n)
module spw_light_pll_supervisor #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 3,
    parameter int CNT_W            = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic [1:0]       lock_sync;
    logic             locked_s;
    logic             pll_rst_nxt, run_nxt, fault_nxt;

    assign locked_s = lock_sync[1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            lock_sync <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lock_sync <= {lock_sync[0], locked};
            retry_cnt <= retry_nxt;
            loss_cnt  <= loss_nxt;
            pll_rst   <= pll_rst_nxt;
            sys_rst_n <= run_nxt;
            ready     <= run_nxt;
            fault     <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;

        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = RESET_PLL;
                        retry_nxt = retry_cnt + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE: begin
                // A dropout only restarts the lock wait; it is not a retry.
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                    if (loss_cnt != 8'hFF) begin
                        loss_nxt = loss_cnt + 8'd1;
                    end
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase

        // restart overrides the transition but not the lock-loss count above.
        if (restart) begin
            state_nxt = RESET_PLL;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end

        // Outputs are registered images of the next state.
        pll_rst_nxt = (state_nxt == RESET_PLL) || (state_nxt == FAULT);
        run_nxt     = (state_nxt == RUN);
        fault_nxt   = (state_nxt == FAULT);
    end

endmodule

// File: tb/tb_spw_light_pll_supervisor.sv
// Purpose : directed self-checking bench for spw_light_pll_supervisor.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_spw_light_pll_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    localparam int SEL_PLL   = 0;
    localparam int SEL_SYS   = 1;
    localparam int SEL_FAULT = 2;

    spw_light_pll_supervisor #(
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT    (20),
        .STABLE_CYCLES   (8),
        .MAX_RETRIES     (2),
        .CNT_W           (16)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .locked   (locked),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .ready    (ready),
        .fault    (fault),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic cur(input int sel);
        case (sel)
            SEL_PLL: return pll_rst;
            SEL_SYS: return sys_rst_n;
            default: return fault;
        endcase
    endfunction

    // Counts falling edges until the selected output equals val; limit+1 if it never does.
    task automatic wait_sig(input int sel, input logic val, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge refclk);
            cnt++;
        end while (cur(sel) !== val && cnt <= limit);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
        chk({tag, "_loss"}, 32'(loss_cnt), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;

        // Reset state
        @(negedge refclk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Normal bring-up: lock arrives 10 cycles after release
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("bringup_pll_width", 32'(n), 32'd4);
        repeat (6) @(negedge refclk);
        locked = 1'b1;
        wait_sig(SEL_SYS, 1'b1, 100, n);
        chk("bringup_release_edges", 32'(n), 32'd11);
        chk("bringup_ready", 32'(ready), 32'd1);
        chk("bringup_fault", 32'(fault), 32'd0);
        chk("bringup_retry", 32'(retry_cnt), 32'd0);
        chk("bringup_pll_low", 32'(pll_rst), 32'd0);

        // Lock loss in RUN for 3 cycles
        locked = 1'b0;
        wait_sig(SEL_SYS, 1'b0, 100, n);
        chk("loss_sys_fall_edges", 32'(n), 32'd3);
        chk("loss_ready", 32'(ready), 32'd0);
        chk("loss_cnt_1", 32'(loss_cnt), 32'd1);
        chk("loss_retry", 32'(retry_cnt), 32'd0);
        chk("loss_pll_rst", 32'(pll_rst), 32'd1);
        locked = 1'b1;
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("loss_pll_width", 32'(n), 32'd4);
        wait_sig(SEL_SYS, 1'b1, 100, n);
        chk("loss_rerelease_edges", 32'(n), 32'd9);
        chk("loss_cnt_kept", 32'(loss_cnt), 32'd1);

        // Asynchronous reset mid-RUN
        repeat (2) @(negedge refclk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("arst_run");
        locked = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;

        // Lock glitch: 5 cycles high, 3 low, then stable
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("glitch_pll_width", 32'(n), 32'd4);
        locked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge refclk);
            chk("glitch_no_release", 32'(sys_rst_n), 32'd0);
        end
        locked = 1'b0;
        repeat (3) @(negedge refclk);
        chk("glitch_retry", 32'(retry_cnt), 32'd0);
        chk("glitch_sys_low", 32'(sys_rst_n), 32'd0);
        locked = 1'b1;
        wait_sig(SEL_SYS, 1'b1, 100, n);
        chk("glitch_release_edges", 32'(n), 32'd11);
        chk("glitch_retry_after", 32'(retry_cnt), 32'd0);

        // Lock never arrives: retries then FAULT
        #2 rst_n = 1'b0;
        locked = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("to_pulse0_width", 32'(n), 32'd4);
        wait_sig(SEL_PLL, 1'b1, 100, n);
        chk("to_wait0_len", 32'(n), 32'd20);
        chk("to_retry1", 32'(retry_cnt), 32'd1);
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("to_pulse1_width", 32'(n), 32'd4);
        wait_sig(SEL_PLL, 1'b1, 100, n);
        chk("to_wait1_len", 32'(n), 32'd20);
        chk("to_retry2", 32'(retry_cnt), 32'd2);
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("to_pulse2_width", 32'(n), 32'd4);
        wait_sig(SEL_FAULT, 1'b1, 100, n);
        chk("to_fault_edges", 32'(n), 32'd20);
        chk("to_fault_pll_rst", 32'(pll_rst), 32'd1);
        chk("to_fault_sys", 32'(sys_rst_n), 32'd0);
        chk("to_fault_retry", 32'(retry_cnt), 32'd2);
        repeat (30) @(negedge refclk);
        chk("fault_hold", 32'(fault), 32'd1);
        chk("fault_hold_pll", 32'(pll_rst), 32'd1);
        chk("fault_hold_sys", 32'(sys_rst_n), 32'd0);

        // restart out of FAULT with lock present
        locked = 1'b1;
        repeat (3) @(negedge refclk);
        restart = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
        chk("restart_fault_clr", 32'(fault), 32'd0);
        chk("restart_retry_clr", 32'(retry_cnt), 32'd0);
        chk("restart_pll_rst", 32'(pll_rst), 32'd1);
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("restart_pll_width", 32'(n), 32'd4);
        wait_sig(SEL_SYS, 1'b1, 100, n);
        chk("restart_release_edges", 32'(n), 32'd9);
        chk("restart_ready", 32'(ready), 32'd1);

        // restart coinciding with lock loss in RUN still counts the loss
        locked = 1'b0;
        repeat (2) @(negedge refclk);
        restart = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
        chk("prio_loss_cnt", 32'(loss_cnt), 32'd1);
        chk("prio_sys", 32'(sys_rst_n), 32'd0);
        chk("prio_pll_rst", 32'(pll_rst), 32'd1);
        locked = 1'b1;
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("prio_pll_width", 32'(n), 32'd4);
        wait_sig(SEL_SYS, 1'b1, 100, n);
        chk("prio_release_edges", 32'(n), 32'd9);

        // restart in RUN with lock present, then async reset mid-STABLE
        restart = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
        chk("rs_run_sys", 32'(sys_rst_n), 32'd0);
        chk("rs_run_loss_same", 32'(loss_cnt), 32'd1);
        wait_sig(SEL_PLL, 1'b0, 100, n);
        chk("rs_run_pll_width", 32'(n), 32'd4);
        repeat (3) @(negedge refclk);
        chk("stable_not_ready", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("arst_stable");
        @(negedge refclk);
        rst_n = 1'b1;
        repeat (2) @(negedge refclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
